// File: rtl/it_blk_ctrl.sv
// Thumb-2 IT block sequencer for the stage-one pre-decoder: holds ITSTATE,
// evaluates the current condition against APSR and squashes failing slots.
module it_blk_ctrl #(
  parameter int NESTED_IT_FAULT = 1,
  parameter int APSR_W          = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_inst_valid,
  input  logic              i_stall,
  input  logic              i_is_it_inst,
  input  logic [3:0]        i_it_firstcond,
  input  logic [3:0]        i_it_mask,
  input  logic [APSR_W-1:0] i_apsr,
  input  logic              i_flush,
  input  logic              i_itstate_wr,
  input  logic [7:0]        i_itstate_in,
  output logic [7:0]        o_itstate,
  output logic              o_in_it_blk,
  output logic [3:0]        o_cur_cond,
  output logic              o_hint_or_exc,
  output logic              o_last_in_blk,
  output logic              o_it_fault
);

  typedef struct packed {
    logic [3:0] cond;
    logic [3:0] mask;
  } itstate_t;

  localparam int  LP_N  = APSR_W - 1;
  localparam int  LP_Z  = APSR_W - 2;
  localparam int  LP_C  = APSR_W - 3;
  localparam int  LP_V  = APSR_W - 4;
  localparam logic LP_FAULT_EN = (NESTED_IT_FAULT != 0);
  localparam logic [3:0] LP_COND_AL = 4'b1110;

  itstate_t r_itstate;
  itstate_t w_itstate_nxt;
  logic     r_it_fault;
  logic     w_it_fault_nxt;
  logic     w_accept;
  logic     w_in_it_blk;
  logic     w_pass;
  logic     w_n, w_z, w_c, w_v;
  logic     w_unused_q;

  // Condition evaluation on c[3:1]; c[0] inverts, except 1111 which is AL.
  function automatic logic cond_pass(input logic [3:0] c, input logic n,
                                     input logic z, input logic cf,
                                     input logic v);
    logic r;
    case (c[3:1])
      3'b000:  r = z;
      3'b001:  r = cf;
      3'b010:  r = n;
      3'b011:  r = v;
      3'b100:  r = cf & ~z;
      3'b101:  r = (n == v);
      3'b110:  r = (n == v) & ~z;
      default: r = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b1;
    return c[0] ? ~r : r;
  endfunction

  assign w_n        = i_apsr[LP_N];
  assign w_z        = i_apsr[LP_Z];
  assign w_c        = i_apsr[LP_C];
  assign w_v        = i_apsr[LP_V];
  assign w_unused_q = i_apsr[0];

  assign w_accept    = i_inst_valid & ~i_stall;
  assign w_in_it_blk = |r_itstate.mask;
  assign w_pass      = cond_pass(o_cur_cond, w_n, w_z, w_c, w_v);

  always_comb begin
    w_itstate_nxt = r_itstate;
    if (i_itstate_wr)
      w_itstate_nxt = itstate_t'(i_itstate_in);
    else if (i_flush)
      w_itstate_nxt = '0;
    else if (w_accept & i_is_it_inst & ~w_in_it_blk)
      w_itstate_nxt = '{cond: i_it_firstcond, mask: i_it_mask};
    else if (w_accept & w_in_it_blk) begin
      // Shifting [4:0] moves mask[3] into cond[0], which flips T/E per slot.
      if (r_itstate.mask[2:0] == 3'b000)
        w_itstate_nxt = '0;
      else
        w_itstate_nxt = itstate_t'({r_itstate[7:5], r_itstate[3:0], 1'b0});
    end
  end

  assign w_it_fault_nxt = w_accept & w_in_it_blk & i_is_it_inst & LP_FAULT_EN;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_itstate  <= '0;
      r_it_fault <= 1'b0;
    end else begin
      r_itstate  <= w_itstate_nxt;
      r_it_fault <= w_it_fault_nxt;
    end
  end

  assign o_itstate     = r_itstate;
  assign o_in_it_blk   = w_in_it_blk;
  assign o_cur_cond    = w_in_it_blk ? r_itstate.cond : LP_COND_AL;
  // A nested IT is squashed even if its slot condition passes.
  assign o_hint_or_exc = i_inst_valid & w_in_it_blk & (~w_pass | i_is_it_inst);
  assign o_last_in_blk = (r_itstate.mask == 4'b1000);
  assign o_it_fault    = r_it_fault;

endmodule

// File: tb/tb_it_blk_ctrl.sv
// Directed bench for it_blk_ctrl: hand-computed ITSTATE sequences and squash decisions.
module tb_it_blk_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inst_valid, stall, is_it, flush, wr;
  logic [3:0] fc, mk;
  logic [4:0] apsr;
  logic [7:0] itin;
  logic [7:0] itstate;
  logic       in_blk, sq_o, last, fault;
  logic [3:0] cur;
  int         n_pass = 0;
  int         n_tot  = 0;

  it_blk_ctrl #(.NESTED_IT_FAULT(1), .APSR_W(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_inst_valid(inst_valid), .i_stall(stall),
    .i_is_it_inst(is_it), .i_it_firstcond(fc), .i_it_mask(mk), .i_apsr(apsr),
    .i_flush(flush), .i_itstate_wr(wr), .i_itstate_in(itin),
    .o_itstate(itstate), .o_in_it_blk(in_blk), .o_cur_cond(cur),
    .o_hint_or_exc(sq_o), .o_last_in_blk(last), .o_it_fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drive one cycle's inputs shortly after the edge, then let comb settle.
  task automatic drv(input logic v, input logic s, input logic it, input logic [3:0] f,
                     input logic [3:0] m, input logic fl, input logic w, input logic [7:0] wi);
    inst_valid = v; stall = s; is_it = it; fc = f; mk = m; flush = fl; wr = w; itin = wi;
    #1;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // One ordinary in-block instruction: check cond/squash, clock, check new ITSTATE.
  task automatic slot(input string tag, input logic [3:0] e_cur, input logic e_hint,
                      input logic [7:0] e_nxt);
    drv(1, 0, 0, 4'h0, 4'h0, 0, 0, 8'h00);
    chk({tag, " cur"}, cur, e_cur);
    chk({tag, " hint"}, sq_o, e_hint);
    tick;
    chk({tag, " its"}, itstate, e_nxt);
  endtask

  task automatic load_it(input string tag, input logic [3:0] f, input logic [3:0] m);
    drv(1, 0, 1, f, m, 0, 0, 8'h00);
    chk({tag, " it exec"}, sq_o, 1'b0);
    tick;
    chk({tag, " load"}, itstate, {f, m});
  endtask

  typedef struct { logic [7:0] st; logic [4:0] ap; logic hint; } cvec_t;
  cvec_t cv[6];

  initial begin
    rst_n = 1'b0; apsr = 5'b0;
    drv(0, 0, 0, 4'h0, 4'h0, 0, 0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("rst its", itstate, 8'h00);
    chk("rst cur", cur, 4'b1110);
    chk("rst hint", sq_o, 1'b0);
    chk("rst inblk", in_blk, 1'b0);
    chk("rst last", last, 1'b0);
    chk("rst fault", fault, 1'b0);
    rst_n = 1'b1;
    tick;
    drv(1, 0, 0, 4'h0, 4'h0, 0, 0, 8'h00);
    chk("idle hint", sq_o, 1'b0);
    tick;

    // ITTE EQ, Z=1
    apsr = 5'b01000;
    load_it("t2", 4'h0, 4'h6);
    chk("t2 inblk", in_blk, 1'b1);
    slot("t2 s1", 4'h0, 1'b0, 8'h0C);
    slot("t2 s2", 4'h0, 1'b0, 8'h18);
    chk("t2 last", last, 1'b1);
    slot("t2 s3", 4'h1, 1'b1, 8'h00);
    chk("t2 inblk end", in_blk, 1'b0);

    // Same block, Z=0, loaded with no bubble
    apsr = 5'b00000;
    load_it("t3", 4'h0, 4'h6);
    slot("t3 s1", 4'h0, 1'b1, 8'h0C);
    slot("t3 s2", 4'h0, 1'b1, 8'h18);
    slot("t3 s3", 4'h1, 1'b0, 8'h00);

    // ITT GE, N!=V, stalled on first slot
    apsr = 5'b10000;
    load_it("t4", 4'hA, 4'h4);
    drv(1, 1, 0, 4'h0, 4'h0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t4 stall its", itstate, 8'hA4);
    end
    slot("t4 s1", 4'hA, 1'b1, 8'hA8);
    slot("t4 s2", 4'hA, 1'b1, 8'h00);

    // Flush mid-block, then a fresh IT, then itstate_wr beating flush
    apsr = 5'b01000;
    load_it("t5", 4'h0, 4'h2);
    slot("t5 s1", 4'h0, 1'b0, 8'h04);
    drv(1, 0, 0, 4'h0, 4'h0, 1, 0, 8'h00);
    tick;
    chk("t5 flush", itstate, 8'h00);
    load_it("t5 re", 4'h1, 4'h8);
    chk("t5 fault", fault, 1'b0);
    drv(0, 0, 0, 4'h0, 4'h0, 1, 1, 8'h46);
    tick;
    chk("t5 wr>flush", itstate, 8'h46);
    drv(0, 0, 0, 4'h0, 4'h0, 1, 0, 8'h00);
    tick;
    chk("t5 flush2", itstate, 8'h00);

    // Nested IT
    apsr = 5'b01000;
    load_it("t6", 4'h0, 4'h4);
    drv(1, 0, 1, 4'hA, 4'h8, 0, 0, 8'h00);
    chk("t6 nest hint", sq_o, 1'b1);
    tick;
    chk("t6 its adv", itstate, 8'h08);
    chk("t6 fault on", fault, 1'b1);
    drv(0, 0, 0, 4'h0, 4'h0, 0, 0, 8'h00);
    tick;
    chk("t6 fault off", fault, 1'b0);
    chk("t6 its hold", itstate, 8'h08);
    slot("t6 s2", 4'h0, 1'b0, 8'h00);

    // Condition table via restored single-slot ITSTATE
    cv[0] = '{8'hF8, 5'b00000, 1'b0}; // 1111 treated as AL
    cv[1] = '{8'h88, 5'b00100, 1'b0}; // HI, C=1 Z=0
    cv[2] = '{8'h98, 5'b00100, 1'b1}; // LS, C=1 Z=0
    cv[3] = '{8'hD8, 5'b01000, 1'b0}; // LE, Z=1
    cv[4] = '{8'hD8, 5'b00000, 1'b1}; // LE, GT true
    cv[5] = '{8'h68, 5'b00010, 1'b1}; // VS, V=0? no: V=1 -> pass... see below
    cv[5] = '{8'h78, 5'b00010, 1'b1}; // VC, V=1
    for (int i = 0; i < 6; i++) begin
      drv(0, 0, 0, 4'h0, 4'h0, 0, 1, cv[i].st);
      tick;
      apsr = cv[i].ap;
      slot($sformatf("cond%0d", i), cv[i].st[7:4], cv[i].hint, 8'h00);
    end

    // Asynchronous reset mid-block
    drv(0, 0, 0, 4'h0, 4'h0, 0, 1, 8'h46);
    tick;
    drv(0, 0, 0, 4'h0, 4'h0, 0, 0, 8'h00);
    rst_n = 1'b0;
    #1;
    chk("async rst its", itstate, 8'h00);
    chk("async rst inblk", in_blk, 1'b0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("post rst its", itstate, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
